carregador_matrizes: RTL and testbench

CARREGADOR_MATRIZES -- requirements
Module: carregador_matrizes

---
 rtl/carregador_matrizes.sv | 144 ++++++++++++++
 tb/tb_carregador_matrizes.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/carregador_matrizes.sv
// Loads a header, two 5x5 operand matrices and an optional scalar from a byte stream, then holds them for the operation unit.
// Latency: saida_valida rises one cycle after the final byte; the stream is stalled (dado_pronto=0) until saida_aceita.
module carregador_matrizes #(
    parameter int N_ELEM = 25,
    parameter int LARG   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [LARG-1:0]          dado_in,
    input  logic                     dado_valido,
    output logic                     dado_pronto,
    input  logic                     cancelar,
    output logic [2:0]               operacao,
    output logic [0:N_ELEM*LARG-1]   matriz_a,
    output logic [0:N_ELEM*LARG-1]   matriz_b,
    output logic signed [LARG-1:0]   escalar,
    output logic                     saida_valida,
    input  logic                     saida_aceita,
    output logic                     erro
);

    localparam int CW = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam logic [CW-1:0] ULTIMO = CW'(N_ELEM - 1);

    typedef enum logic [2:0] {
        OCIOSO,
        RECEBE_A,
        RECEBE_B,
        RECEBE_ESC,
        ENTREGA
    } estado_t;

    estado_t                   estado_q, estado_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [2:0]                op_q, op_d;
    logic [0:N_ELEM*LARG-1]    ma_q, ma_d;
    logic [0:N_ELEM*LARG-1]    mb_q, mb_d;
    logic signed [LARG-1:0]    esc_q, esc_d;
    logic                      erro_q, erro_d;
    logic                      transf;

    assign dado_pronto  = (estado_q != ENTREGA);
    assign saida_valida = (estado_q == ENTREGA);
    assign transf       = dado_valido && dado_pronto;
    assign operacao     = op_q;
    assign matriz_a     = ma_q;
    assign matriz_b     = mb_q;
    assign escalar      = esc_q;
    assign erro         = erro_q;

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        esc_d    = esc_q;
        erro_d   = 1'b0;

        // An abort wins over any byte or handoff in the same cycle; latched operands are kept.
        if (cancelar && (estado_q != OCIOSO)) begin
            estado_d = OCIOSO;
            cnt_d    = '0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (transf) begin
                        if (dado_in[2:0] <= 3'd5) begin
                            op_d     = dado_in[2:0];
                            mb_d     = '0;
                            esc_d    = '0;
                            cnt_d    = '0;
                            estado_d = RECEBE_A;
                        end else begin
                            erro_d = 1'b1;
                        end
                    end
                end
                RECEBE_A: begin
                    if (transf) begin
                        ma_d[LARG*int'(cnt_q) +: LARG] = dado_in;
                        if (cnt_q == ULTIMO) begin
                            cnt_d = '0;
                            case (op_q)
                                3'd2:       estado_d = RECEBE_ESC;
                                3'd3, 3'd4: estado_d = ENTREGA;
                                default:    estado_d = RECEBE_B;
                            endcase
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                RECEBE_B: begin
                    if (transf) begin
                        mb_d[LARG*int'(cnt_q) +: LARG] = dado_in;
                        if (cnt_q == ULTIMO) begin
                            cnt_d    = '0;
                            estado_d = ENTREGA;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                RECEBE_ESC: begin
                    if (transf) begin
                        esc_d    = $signed(dado_in);
                        estado_d = ENTREGA;
                    end
                end
                ENTREGA: begin
                    if (saida_aceita) begin
                        estado_d = OCIOSO;
                    end
                end
                default: begin
                    estado_d = OCIOSO;
                    cnt_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_q <= OCIOSO;
            cnt_q    <= '0;
            op_q     <= '0;
            ma_q     <= '0;
            mb_q     <= '0;
            esc_q    <= '0;
            erro_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            ma_q     <= ma_d;
            mb_q     <= mb_d;
            esc_q    <= esc_d;
            erro_q   <= erro_d;
        end
    end

endmodule

// File: tb/tb_carregador_matrizes.sv
// Self-checking bench for carregador_matrizes: directed scenarios plus randomized transfers against a byte-list model.
module tb_carregador_matrizes;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [7:0]         dado_in = 8'h00;
    logic               dado_valido = 1'b0;
    logic               dado_pronto;
    logic               cancelar = 1'b0;
    logic [2:0]         operacao;
    logic [0:199]       matriz_a;
    logic [0:199]       matriz_b;
    logic signed [7:0]  escalar;
    logic               saida_valida;
    logic               saida_aceita = 1'b0;
    logic               erro;

    int checks = 0;
    int failures = 0;
    logic pronto_pre;

    logic [7:0] pl[$];
    logic [7:0] ea[25];
    logic [7:0] eb[25];
    logic [7:0] ee;
    logic [2:0] eo;

    carregador_matrizes #(.N_ELEM(25), .LARG(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dado_in     (dado_in),
        .dado_valido (dado_valido),
        .dado_pronto (dado_pronto),
        .cancelar    (cancelar),
        .operacao    (operacao),
        .matriz_a    (matriz_a),
        .matriz_b    (matriz_b),
        .escalar     (escalar),
        .saida_valida(saida_valida),
        .saida_aceita(saida_aceita),
        .erro        (erro)
    );

    always #5 clk = ~clk;

    // Element k lives at bits [8k:8k+7] of an ascending vector, MSB at bit 8k.
    function automatic logic [0:199] pack(input logic [7:0] e[25]);
        logic [0:199] r;
        r = '0;
        for (int k = 0; k < 25; k++) r[8*k +: 8] = e[k];
        return r;
    endfunction

    function automatic int total_bytes(input logic [2:0] op);
        case (op)
            3'd0, 3'd1, 3'd5: return 51;
            3'd2:             return 27;
            default:          return 26;
        endcase
    endfunction

    task automatic cyc(input logic v, input logic [7:0] d, input logic c, input logic a);
        @(negedge clk);
        dado_valido  = v;
        dado_in      = d;
        cancelar     = c;
        saida_aceita = a;
        #1 pronto_pre = dado_pronto;
        @(posedge clk);
        #1;
    endtask

    task automatic send_seq(input int from, input int upto, input int gapmax);
        for (int i = from; i < upto; i++) begin
            int g;
            g = $urandom_range(0, gapmax);
            repeat (g) cyc(1'b0, 8'($urandom), 1'b0, 1'($urandom_range(0, 1)));
            cyc(1'b1, pl[i], 1'b0, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic make_pl(input logic [7:0] hdr);
        int n;
        n = total_bytes(hdr[2:0]);
        pl.delete();
        pl.push_back(hdr);
        for (int i = 1; i < n; i++) pl.push_back(8'($urandom));
    endtask

    task automatic model_load(input logic [2:0] op);
        for (int k = 0; k < 25; k++) ea[k] = pl[1+k];
        for (int k = 0; k < 25; k++) eb[k] = 8'h00;
        ee = 8'h00;
        if (op == 3'd0 || op == 3'd1 || op == 3'd5)
            for (int k = 0; k < 25; k++) eb[k] = pl[26+k];
        if (op == 3'd2) ee = pl[26];
        eo = op;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 8'h01, 1'b1, 1'b1);
        checks++; if (operacao !== 3'd0) begin failures++; $display("FAIL reset_op got=%0d exp=0", operacao); end
        checks++; if (matriz_a !== '0 || matriz_b !== '0) begin failures++; $display("FAIL reset_mat got a=%h b=%h exp=0", matriz_a, matriz_b); end
        checks++; if (escalar !== 8'sd0 || saida_valida !== 1'b0 || erro !== 1'b0) begin failures++; $display("FAIL reset_misc got esc=%h sv=%b erro=%b exp=0", escalar, saida_valida, erro); end
        rst_n = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (dado_pronto !== 1'b1) begin failures++; $display("FAIL reset_pronto got=%b exp=1", dado_pronto); end
        for (int k = 0; k < 25; k++) begin ea[k] = 8'h00; eb[k] = 8'h00; end
        ee = 8'h00; eo = 3'd0;
    endtask

    task automatic test_full_ab;
        pl.delete();
        pl.push_back(8'h00);
        for (int i = 1; i <= 25; i++) pl.push_back(8'(i));
        for (int i = 25; i >= 1; i--) pl.push_back(8'(i));
        send_seq(0, 50, 0);
        checks++; if (saida_valida !== 1'b0) begin failures++; $display("FAIL ab_early_valid got=%b exp=0", saida_valida); end
        send_seq(50, 51, 0);
        model_load(3'd0);
        checks++; if (saida_valida !== 1'b1) begin failures++; $display("FAIL ab_valid got=%b exp=1", saida_valida); end
        checks++; if (matriz_a[0:7] !== 8'd1 || matriz_a[192:199] !== 8'd25 || matriz_b[0:7] !== 8'd25) begin failures++; $display("FAIL ab_corners got a0=%0d a24=%0d b0=%0d exp=1 25 25", matriz_a[0:7], matriz_a[192:199], matriz_b[0:7]); end
        checks++; if (matriz_a !== pack(ea) || matriz_b !== pack(eb)) begin failures++; $display("FAIL ab_mats got a=%h b=%h", matriz_a, matriz_b); end
        checks++; if (operacao !== 3'd0) begin failures++; $display("FAIL ab_op got=%0d exp=0", operacao); end
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (saida_valida !== 1'b0 || dado_pronto !== 1'b1) begin failures++; $display("FAIL ab_handoff got sv=%b pronto=%b exp=0 1", saida_valida, dado_pronto); end
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (matriz_a !== pack(ea) || matriz_b !== pack(eb) || operacao !== eo) begin failures++; $display("FAIL ab_hold got op=%0d a=%h", operacao, matriz_a); end
    endtask

    task automatic test_bad_header;
        cyc(1'b1, 8'h06, 1'b0, 1'b0);
        checks++; if (erro !== 1'b1) begin failures++; $display("FAIL bad_erro_pulse got=%b exp=1", erro); end
        checks++; if (operacao !== eo || dado_pronto !== 1'b1) begin failures++; $display("FAIL bad_op_kept got op=%0d pronto=%b exp op=%0d pronto=1", operacao, dado_pronto, eo); end
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (erro !== 1'b0) begin failures++; $display("FAIL bad_erro_width got=%b exp=0", erro); end
        cyc(1'b1, 8'hFF, 1'b0, 1'b0);
        checks++; if (erro !== 1'b1 || operacao !== eo) begin failures++; $display("FAIL bad_hdr_ff got erro=%b op=%0d exp 1 %0d", erro, operacao, eo); end
        make_pl(8'h03);
        send_seq(0, 26, 0);
        model_load(3'd3);
        checks++; if (saida_valida !== 1'b1 || erro !== 1'b0) begin failures++; $display("FAIL bad_then_op3 got sv=%b erro=%b exp=1 0", saida_valida, erro); end
        checks++; if (matriz_b !== '0 || matriz_a !== pack(ea) || operacao !== 3'd3) begin failures++; $display("FAIL op3_data got op=%0d b=%h", operacao, matriz_b); end
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_scalar_gaps;
        int n;
        n = 0;
        pl.delete();
        pl.push_back(8'h02);
        for (int i = 0; i < 25; i++) pl.push_back(8'hFF);
        pl.push_back(8'h03);
        for (int i = 0; i < 27; i++) begin
            cyc(1'b0, 8'h55, 1'b0, 1'b0);
            if (i == 26) begin
                checks++; if (saida_valida !== 1'b0) begin failures++; $display("FAIL esc_early_valid got=%b exp=0", saida_valida); end
            end
            cyc(1'b1, pl[i], 1'b0, 1'b0);
            if (pronto_pre) n++;
        end
        model_load(3'd2);
        checks++; if (n !== 27 || saida_valida !== 1'b1) begin failures++; $display("FAIL esc_count got n=%0d sv=%b exp=27 1", n, saida_valida); end
        checks++; if (escalar !== 8'sd3 || matriz_b !== '0 || operacao !== 3'd2) begin failures++; $display("FAIL esc_data got esc=%0d op=%0d b=%h exp esc=3 op=2 b=0", escalar, operacao, matriz_b); end
        checks++; if (matriz_a !== pack(ea)) begin failures++; $display("FAIL esc_mat_a got=%h", matriz_a); end
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_cancel;
        logic [7:0] hdr;
        make_pl(8'h05);
        send_seq(0, 11, 1);
        for (int k = 0; k < 10; k++) ea[k] = pl[1+k];
        for (int k = 0; k < 25; k++) eb[k] = 8'h00;
        ee = 8'h00; eo = 3'd5;
        cyc(1'b1, 8'hAA, 1'b1, 1'b0);
        checks++; if (saida_valida !== 1'b0 || dado_pronto !== 1'b1 || erro !== 1'b0) begin failures++; $display("FAIL cancel_state got sv=%b pronto=%b erro=%b exp=0 1 0", saida_valida, dado_pronto, erro); end
        checks++; if (matriz_a !== pack(ea) || matriz_b !== '0 || operacao !== 3'd5 || escalar !== 8'sd0) begin failures++; $display("FAIL cancel_kept got op=%0d a=%h", operacao, matriz_a); end
        hdr = {5'b10101, 3'd1};
        make_pl(hdr);
        send_seq(0, 50, 1);
        checks++; if (saida_valida !== 1'b0) begin failures++; $display("FAIL cancel_fresh_early got=%b exp=0", saida_valida); end
        send_seq(50, 51, 1);
        model_load(3'd1);
        checks++; if (saida_valida !== 1'b1 || matriz_a !== pack(ea) || matriz_b !== pack(eb) || operacao !== 3'd1) begin failures++; $display("FAIL cancel_fresh got sv=%b op=%0d", saida_valida, operacao); end
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_hold;
        int bad;
        bad = 0;
        make_pl(8'h04);
        send_seq(0, 26, 0);
        model_load(3'd4);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
            if (dado_pronto !== 1'b0 || saida_valida !== 1'b1 || matriz_a !== pack(ea) || matriz_b !== '0 || operacao !== 3'd4) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL hold_stable got bad_cycles=%0d exp=0", bad); end
        cyc(1'b1, 8'h11, 1'b0, 1'b1);
        checks++; if (saida_valida !== 1'b0 || dado_pronto !== 1'b1 || matriz_a !== pack(ea)) begin failures++; $display("FAIL hold_release got sv=%b pronto=%b exp=0 1", saida_valida, dado_pronto); end
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid;
        int seen;
        seen = 0;
        make_pl(8'h01);
        send_seq(0, 31, 0);
        rst_n = 1'b0;
        cyc(1'b1, 8'h33, 1'b1, 1'b1);
        checks++; if (operacao !== 3'd0 || matriz_a !== '0 || matriz_b !== '0 || escalar !== 8'sd0 || saida_valida !== 1'b0 || erro !== 1'b0) begin failures++; $display("FAIL midreset_clear got op=%0d sv=%b a=%h", operacao, saida_valida, matriz_a); end
        rst_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b0);
            if (saida_valida !== 1'b0) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL midreset_no_valid got=%0d exp=0", seen); end
        for (int k = 0; k < 25; k++) begin ea[k] = 8'h00; eb[k] = 8'h00; end
        ee = 8'h00; eo = 3'd0;
    endtask

    task automatic test_random;
        for (int it = 0; it < 10; it++) begin
            logic [2:0] op;
            int n, h;
            op = 3'($urandom_range(0, 5));
            make_pl({5'($urandom), op});
            n = total_bytes(op);
            send_seq(0, n - 1, 2);
            checks++; if (saida_valida !== 1'b0) begin failures++; $display("FAIL rnd_early it=%0d op=%0d got=%b exp=0", it, op, saida_valida); end
            send_seq(n - 1, n, 2);
            model_load(op);
            checks++; if (saida_valida !== 1'b1 || operacao !== eo) begin failures++; $display("FAIL rnd_valid it=%0d got sv=%b op=%0d exp 1 %0d", it, saida_valida, operacao, eo); end
            checks++; if (matriz_a !== pack(ea) || matriz_b !== pack(eb) || escalar !== ee) begin failures++; $display("FAIL rnd_data it=%0d op=%0d esc=%h exp=%h", it, op, escalar, ee); end
            h = $urandom_range(0, 3);
            repeat (h) cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 1'b0);
            cyc(1'b0, 8'h00, 1'b0, 1'b1);
            checks++; if (saida_valida !== 1'b0 || dado_pronto !== 1'b1) begin failures++; $display("FAIL rnd_handoff it=%0d got sv=%b pronto=%b", it, saida_valida, dado_pronto); end
        end
    endtask

    initial begin
        test_reset;
        test_full_ab;
        test_bad_header;
        test_scalar_gaps;
        test_cancel;
        test_hold;
        test_reset_mid;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
